// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron datapath.
//   DATA_W_DEF : default membrane/threshold width
//   state_t    : spike generator FSM states
//   sat_add    : saturating add used by the spike counter and adaptive threshold
package snn_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    INTEG  = 2'd0,
    FIRE   = 2'd1,
    REFRAC = 2'd2
  } state_t;

  // Adds step to val and clamps the result at max_val (33-bit sum avoids wrap).
  function automatic logic [31:0] sat_add(input logic [31:0] val,
                                          input logic [31:0] step,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, val} + {1'b0, step};
    if (sum > {1'b0, max_val}) begin
      return max_val;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/spike_gen_if.sv
// Bus bundle between the membrane accumulator, the spike generator and the
// next layer.
//   slave  : spike generator side (samples en/v_mem/v_valid/thr_*/spike_ready,
//            drives spk/acc_clear/spike_valid/overrun/spike_count/busy_refrac)
//   master : environment side (mirror image)
interface spike_gen_if #(
  parameter int unsigned DATA_W = snn_pkg::DATA_W_DEF,
  parameter int unsigned CNT_W  = 16
);

  logic                     en;
  logic signed [DATA_W-1:0] v_mem;
  logic                     v_valid;
  logic signed [DATA_W-1:0] thr_in;
  logic                     thr_load;
  logic                     spk;
  logic                     acc_clear;
  logic                     spike_valid;
  logic                     spike_ready;
  logic                     overrun;
  logic [CNT_W-1:0]         spike_count;
  logic                     busy_refrac;

  modport master (
    output en, v_mem, v_valid, thr_in, thr_load, spike_ready,
    input  spk, acc_clear, spike_valid, overrun, spike_count, busy_refrac
  );

  modport slave (
    input  en, v_mem, v_valid, thr_in, thr_load, spike_ready,
    output spk, acc_clear, spike_valid, overrun, spike_count, busy_refrac
  );

endinterface

// File: rtl/spike_gen_refrac_counter.sv
// Refractory strobe counter: counts i_inc pulses and raises o_done_c
// combinationally on the pulse that completes STEPS counts, wrapping to 0.
//   clk, rst  : clock, synchronous active-high reset
//   i_clr     : synchronous clear
//   i_inc     : count one strobe
//   o_done_c  : this strobe completes the refractory period
module spike_gen_refrac_counter #(
  parameter int unsigned STEPS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_done_c
);

  localparam int unsigned CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = (STEPS > 0) ? CW'(STEPS - 1) : '0;

  logic [CW-1:0] r_cnt;

  assign o_done_c = i_inc & (r_cnt == LAST);

  // Count strobes; the completing strobe returns the counter to zero.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= o_done_c ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spike_gen.sv
// Spike generator: samples the signed membrane potential on each time-step
// strobe, fires when it reaches the threshold, pulses spk/acc_clear back to
// the accumulator, offers a token to the next layer over valid/ready and
// then holds off for REFRAC_STEPS strobes.
//   clk, rst : clock, synchronous active-high reset
//   bus      : spike_gen_if.slave (en, v_mem, v_valid, thr_in, thr_load,
//              spike_ready in; spk, acc_clear, spike_valid, overrun,
//              spike_count, busy_refrac out; all outputs registered)
// Optional build macro SPIKE_GEN_ADAPTIVE_THRESH_EN adds an adaptive
// threshold offset that rises on every spike and decays on quiet strobes.
module spike_gen import snn_pkg::*; #(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int          THRESH       = 64,
  parameter int unsigned REFRAC_STEPS = 3,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned ADAPT_STEP   = 8
) (
  input  logic        clk,
  input  logic        rst,
  spike_gen_if.slave  bus
);

  // Two guard bits so thr + adapt never wraps during the compare.
  localparam int unsigned CMP_W = DATA_W + 2;
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic signed [DATA_W-1:0] THR_RST = DATA_W'(THRESH);

  state_t                   r_state;
  state_t                   w_state_next;
  logic signed [DATA_W-1:0] r_thr;
  logic [CNT_W-1:0]         r_count;
  logic                     r_spk;
  logic                     r_spike_valid;
  logic                     r_overrun;
  logic                     r_busy;

  logic                     w_strobe;
  logic                     w_fire;
  logic                     w_accept;
  logic                     w_refrac_inc;
  logic                     w_refrac_clr;
  logic                     w_refrac_done;
  logic [CNT_W-1:0]         w_count_next;
  logic                     w_spike_valid_next;
  logic                     w_overrun_next;
  logic signed [CMP_W-1:0]  w_vmem_ext;
  logic signed [CMP_W-1:0]  w_thr_ext;
  logic signed [CMP_W-1:0]  w_eff_thr;

  assign w_strobe     = bus.en & bus.v_valid;
  assign w_accept     = r_spike_valid & bus.spike_ready;
  assign w_vmem_ext   = {{2{bus.v_mem[DATA_W-1]}}, bus.v_mem};
  assign w_thr_ext    = {{2{r_thr[DATA_W-1]}}, r_thr};
  assign w_refrac_inc = (r_state == REFRAC) & w_strobe;
  assign w_refrac_clr = (r_state != REFRAC);

  spike_gen_refrac_counter #(
    .STEPS (REFRAC_STEPS)
  ) u_refrac (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_refrac_clr),
    .i_inc    (w_refrac_inc),
    .o_done_c (w_refrac_done)
  );

`ifdef SPIKE_GEN_ADAPTIVE_THRESH_EN
  localparam logic signed [CMP_W-1:0] MAX_POS = CMP_W'((64'd1 << (DATA_W - 1)) - 64'd1);

  logic [DATA_W-1:0]       r_adapt;
  logic [DATA_W-1:0]       w_adapt_next;
  logic signed [CMP_W-1:0] w_headroom;

  assign w_eff_thr  = w_thr_ext + $signed({2'b00, r_adapt});
  // Largest adapt keeping thr + adapt at or below the maximum positive value.
  assign w_headroom = MAX_POS - w_thr_ext;

  // Rise by ADAPT_STEP on each spike, decay by one on each quiet strobe.
  always_comb begin
    w_adapt_next = r_adapt;
    if (w_fire) begin
      w_adapt_next = DATA_W'(sat_add(32'(r_adapt), 32'(ADAPT_STEP), 32'(w_headroom)));
    end else if ((r_state == INTEG) && w_strobe && (r_adapt != '0)) begin
      w_adapt_next = r_adapt - DATA_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_adapt <= '0;
    end else begin
      r_adapt <= w_adapt_next;
    end
  end
`else
  assign w_eff_thr = w_thr_ext;
`endif

  // Next state plus next values of every registered output.
  always_comb begin
    w_state_next       = r_state;
    w_fire             = 1'b0;
    w_count_next       = r_count;
    w_spike_valid_next = r_spike_valid;
    w_overrun_next     = r_overrun;

    case (r_state)
      INTEG: begin
        if (w_strobe && (w_vmem_ext >= w_eff_thr)) begin
          w_fire       = 1'b1;
          w_state_next = FIRE;
        end
      end
      // FIRE always lasts one cycle, even with en low.
      FIRE: begin
        w_state_next = (REFRAC_STEPS > 0) ? REFRAC : INTEG;
      end
      REFRAC: begin
        if (w_refrac_done) begin
          w_state_next = INTEG;
        end
      end
      default: begin
        w_state_next = INTEG;
      end
    endcase

    // A new spike re-arms the token even if the old one is accepted now.
    if (w_fire) begin
      w_spike_valid_next = 1'b1;
      w_count_next       = CNT_W'(sat_add(32'(r_count), 32'd1, CNT_MAX));
      if (r_spike_valid && !bus.spike_ready) begin
        w_overrun_next = 1'b1;
      end
    end else if (w_accept) begin
      w_spike_valid_next = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= INTEG;
      r_spk         <= 1'b0;
      r_spike_valid <= 1'b0;
      r_overrun     <= 1'b0;
      r_busy        <= 1'b0;
      r_count       <= '0;
    end else begin
      r_state       <= w_state_next;
      r_spk         <= (w_state_next == FIRE);
      r_spike_valid <= w_spike_valid_next;
      r_overrun     <= w_overrun_next;
      r_busy        <= (w_state_next == REFRAC);
      r_count       <= w_count_next;
    end
  end

  // Threshold register; a load lands at the edge, so a same-cycle compare sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_thr <= THR_RST;
    end else if (bus.en && bus.thr_load) begin
      r_thr <= bus.thr_in;
    end
  end

  assign bus.spk         = r_spk;
  assign bus.acc_clear   = r_spk;
  assign bus.spike_valid = r_spike_valid;
  assign bus.overrun     = r_overrun;
  assign bus.spike_count = r_count;
  assign bus.busy_refrac = r_busy;

endmodule

// File: tb/tb_spike_gen.sv
// Self-checking bench for spike_gen: expected spikes (cycle and count) are
// queued when a crossing is driven and matched by a monitor on the falling edge.
module tb_spike_gen;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  spike_gen_if #(.DATA_W(8), .CNT_W(16)) bus ();

  spike_gen #(
    .DATA_W       (8),
    .THRESH       (64),
    .REFRAC_STEPS (3),
    .CNT_W        (16),
    .ADAPT_STEP   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int cyc;
    int count;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   exp_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Spike monitor: every spk pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (bus.spk === 1'b1 || bus.acc_clear === 1'b1) begin
      n_checks++;
      if (bus.acc_clear !== bus.spk) begin
        n_fail++;
        $display("FAIL acc_clear_with_spk: acc_clear=%b spk=%b cycle %0d", bus.acc_clear, bus.spk, cyc);
      end
      if (bus.spk === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_spike: spk=1 at cycle %0d, none expected", cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc) begin
            n_fail++;
            $display("FAIL spike_cycle: got cycle %0d want %0d", cyc, e.cyc);
          end
          n_checks++;
          if (bus.spike_count !== 16'(e.count)) begin
            n_fail++;
            $display("FAIL spike_count: got %0d want %0d", bus.spike_count, e.count);
          end
        end
      end
    end
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missed_spike: expected at cycle %0d, none by cycle %0d", e.cyc, cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic signed [7:0] vm);
    bus.v_valid = 1'b1;
    bus.v_mem   = vm;
    step();
    bus.v_valid = 1'b0;
  endtask

  task automatic expect_spike();
    exp_t e;
    exp_count++;
    e.cyc   = cyc + 1;
    e.count = exp_count;
    exp_q.push_back(e);
  endtask

  // Leave FIRE, then supply the three refractory strobes.
  task automatic drain_refrac();
    step();
    repeat (3) strobe(8'sd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1;
    bus.v_valid = 1'b1;
    bus.v_mem = 8'sd100;
    bus.thr_in = 8'sd0;
    bus.thr_load = 1'b0;
    bus.spike_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    bus.v_valid = 1'b0;
    exp_count = 0;
    n_checks++; if (bus.spk !== 1'b0) begin n_fail++; $display("FAIL rst_spk: got %b want 0", bus.spk); end
    n_checks++; if (bus.acc_clear !== 1'b0) begin n_fail++; $display("FAIL rst_acc_clear: got %b want 0", bus.acc_clear); end
    n_checks++; if (bus.spike_valid !== 1'b0) begin n_fail++; $display("FAIL rst_spike_valid: got %b want 0", bus.spike_valid); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b want 0", bus.overrun); end
    n_checks++; if (bus.busy_refrac !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy_refrac); end
    n_checks++; if (bus.spike_count !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", bus.spike_count); end
  endtask

  task automatic test_threshold();
    bus.spike_ready = 1'b1;
    strobe(8'sd63);
    step();
    n_checks++; if (bus.spike_count !== 16'd0) begin n_fail++; $display("FAIL thr_below_count: got %0d want 0", bus.spike_count); end
    expect_spike();
    strobe(8'sd64);
    n_checks++; if (bus.spike_valid !== 1'b1) begin n_fail++; $display("FAIL thr_valid_set: got %b want 1", bus.spike_valid); end
    step();
    n_checks++; if (bus.spike_valid !== 1'b0) begin n_fail++; $display("FAIL thr_valid_drop: got %b want 0", bus.spike_valid); end
    n_checks++; if (bus.busy_refrac !== 1'b1) begin n_fail++; $display("FAIL thr_busy: got %b want 1", bus.busy_refrac); end
  endtask

  task automatic test_refrac();
    strobe(8'sd100);
    n_checks++; if (bus.busy_refrac !== 1'b1) begin n_fail++; $display("FAIL refrac_busy1: got %b want 1", bus.busy_refrac); end
    strobe(8'sd100);
    n_checks++; if (bus.busy_refrac !== 1'b1) begin n_fail++; $display("FAIL refrac_busy2: got %b want 1", bus.busy_refrac); end
    strobe(8'sd100);
    n_checks++; if (bus.busy_refrac !== 1'b0) begin n_fail++; $display("FAIL refrac_exit: got %b want 0", bus.busy_refrac); end
    expect_spike();
    strobe(8'sd100);
    strobe(8'sd0);
    n_checks++; if (bus.busy_refrac !== 1'b1) begin n_fail++; $display("FAIL refrac_after_fire: got %b want 1", bus.busy_refrac); end
    strobe(8'sd0);
    strobe(8'sd0);
    n_checks++; if (bus.busy_refrac !== 1'b1) begin n_fail++; $display("FAIL refrac_fire_strobe_counted: got %b want 1", bus.busy_refrac); end
    strobe(8'sd0);
    n_checks++; if (bus.busy_refrac !== 1'b0) begin n_fail++; $display("FAIL refrac_exit2: got %b want 0", bus.busy_refrac); end
  endtask

  task automatic test_back_to_back();
    bus.spike_ready = 1'b0;
    expect_spike();
    strobe(8'sd127);
    drain_refrac();
    n_checks++; if (bus.spike_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_held: got %b want 1", bus.spike_valid); end
    bus.spike_ready = 1'b1;
    expect_spike();
    strobe(8'sd127);
    n_checks++; if (bus.spike_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_new_token: got %b want 1", bus.spike_valid); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_no_overrun: got %b want 0", bus.overrun); end
    step();
    n_checks++; if (bus.spike_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_delivered: got %b want 0", bus.spike_valid); end
    drain_refrac();
  endtask

  task automatic test_overrun();
    bus.spike_ready = 1'b0;
    expect_spike();
    strobe(8'sd127);
    drain_refrac();
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early: got %b want 0", bus.overrun); end
    expect_spike();
    strobe(8'sd127);
    n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", bus.overrun); end
    n_checks++; if (bus.spike_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", bus.spike_valid); end
    drain_refrac();
    bus.spike_ready = 1'b1;
    step();
    n_checks++; if (bus.spike_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drop: got %b want 0", bus.spike_valid); end
    step();
    n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", bus.overrun); end
  endtask

  task automatic test_enable();
    bus.en = 1'b0;
    strobe(8'sd127);
    step();
    n_checks++; if (bus.busy_refrac !== 1'b0) begin n_fail++; $display("FAIL en_no_fire: got %b want 0", bus.busy_refrac); end
    n_checks++; if (bus.spike_count !== 16'(exp_count)) begin n_fail++; $display("FAIL en_count_frozen: got %0d want %0d", bus.spike_count, exp_count); end
    bus.en = 1'b1;
    bus.spike_ready = 1'b0;
    expect_spike();
    strobe(8'sd127);
    bus.en = 1'b0;
    bus.spike_ready = 1'b1;
    step();
    n_checks++; if (bus.busy_refrac !== 1'b1) begin n_fail++; $display("FAIL en_fire_completes: got %b want 1", bus.busy_refrac); end
    n_checks++; if (bus.spike_valid !== 1'b0) begin n_fail++; $display("FAIL en_handshake: got %b want 0", bus.spike_valid); end
    repeat (3) strobe(8'sd127);
    n_checks++; if (bus.busy_refrac !== 1'b1) begin n_fail++; $display("FAIL en_refrac_frozen: got %b want 1", bus.busy_refrac); end
    bus.en = 1'b1;
    drain_refrac();
    n_checks++; if (bus.busy_refrac !== 1'b0) begin n_fail++; $display("FAIL en_resume: got %b want 0", bus.busy_refrac); end
  endtask

  task automatic test_reset_refrac();
    expect_spike();
    strobe(8'sd127);
    step();
    n_checks++; if (bus.busy_refrac !== 1'b1) begin n_fail++; $display("FAIL rr_in_refrac: got %b want 1", bus.busy_refrac); end
    rst = 1'b1;
    bus.v_valid = 1'b1;
    bus.v_mem = 8'sd100;
    step();
    rst = 1'b0;
    bus.v_valid = 1'b0;
    exp_count = 0;
    n_checks++; if (bus.busy_refrac !== 1'b0) begin n_fail++; $display("FAIL rr_busy: got %b want 0", bus.busy_refrac); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL rr_overrun: got %b want 0", bus.overrun); end
    n_checks++; if (bus.spike_valid !== 1'b0) begin n_fail++; $display("FAIL rr_valid: got %b want 0", bus.spike_valid); end
    n_checks++; if (bus.spk !== 1'b0) begin n_fail++; $display("FAIL rr_spk: got %b want 0", bus.spk); end
    n_checks++; if (bus.spike_count !== 16'd0) begin n_fail++; $display("FAIL rr_count: got %0d want 0", bus.spike_count); end
    strobe(8'sd63);
    step();
    expect_spike();
    strobe(8'sd64);
  endtask

  task automatic test_adaptive();
    drain_refrac();
`ifdef SPIKE_GEN_ADAPTIVE_THRESH_EN
    strobe(8'sd64);
    step();
    expect_spike();
    strobe(8'sd72);
`else
    expect_spike();
    strobe(8'sd64);
    drain_refrac();
    expect_spike();
    strobe(8'sd72);
`endif
    drain_refrac();
  endtask

  task automatic test_thr_load();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_count = 0;
    bus.thr_in = -8'sd10;
    bus.thr_load = 1'b1;
    bus.v_valid = 1'b1;
    bus.v_mem = -8'sd5;
    step();
    bus.thr_load = 1'b0;
    bus.v_valid = 1'b0;
    step();
    n_checks++; if (bus.spike_count !== 16'd0) begin n_fail++; $display("FAIL thrld_old_thr: got %0d want 0", bus.spike_count); end
    expect_spike();
    strobe(-8'sd5);
    drain_refrac();
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_refrac();
    test_back_to_back();
    test_overrun();
    test_enable();
    test_reset_refrac();
    test_adaptive();
    test_thr_load();
    repeat (3) step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_spikes: got %0d outstanding want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spike_gen.md
Name: spike_gen

Overview:
- Downstream stage of the leaky membrane accumulator.
- Samples the signed membrane potential on each time-step strobe and compares it against a programmable threshold.
- On a crossing:
  - emits a one-cycle spike that feeds back to the accumulator's spike-select/clear path;
  - presents a spike token to the next layer via a valid/ready handshake;
  - enforces a refractory period measured in time steps.

Parameters:
- DATA_W, 8, width of signed membrane potential and threshold
- THRESH, 64, threshold value loaded at reset (signed, DATA_W bits)
- REFRAC_STEPS, 3, number of v_valid strobes ignored after a spike (0 = none)
- CNT_W, 16, width of saturating spike counter
- ADAPT_STEP, 8, threshold increment per spike (used only with the optional feature)

Ports:
- clk, input, 1, system clock, rising-edge
- rst, input, 1, reset
- en, input, 1, block enable; low freezes state, counters and outputs except handshake completion
- v_mem, input, DATA_W signed, membrane potential from accumulator
- v_valid, input, 1, one-cycle strobe: v_mem holds a new time-step value
- thr_in, input, DATA_W signed, new threshold value
- thr_load, input, 1, load thr_in into threshold register
- spk, output, 1, one-cycle spike pulse to accumulator
- acc_clear, output, 1, one-cycle request to zero the membrane (coincident with spk)
- spike_valid, output, 1, spike token pending for next layer
- spike_ready, input, 1, next layer accepts token
- overrun, output, 1, sticky: spike generated while previous token still pending
- spike_count, output, CNT_W, saturating count of generated spikes
- busy_refrac, output, 1, high while in REFRAC

Behaviour:
- Reset: rst is synchronous, active-high. On reset:
  - state=INTEG;
  - spk, acc_clear, spike_valid, overrun, busy_refrac all 0;
  - spike_count=0, thr=THRESH, refractory counter=0.
- Reset dominates all other inputs in the same cycle.
- States:
  - INTEG:
    - on en & v_valid & ($signed(v_mem) >= $signed(thr)) -> FIRE;
    - otherwise stay.
  - FIRE (exactly one cycle):
    - spk=1, acc_clear=1;
    - spike_valid set;
    - spike_count += 1, saturating at all-ones.
    - Next state is REFRAC if REFRAC_STEPS>0, else INTEG.
  - REFRAC:
    - each en & v_valid increments the refractory counter; v_mem is ignored;
    - when the counter reaches REFRAC_STEPS, clear it and go to INTEG.
    - A v_valid arriving while in FIRE does not count.
- Latency: a crossing sampled in cycle N gives spk/acc_clear/spike_valid high in cycle N+1, all registered.
- Comparison is signed; negative v_mem never fires when thr >= 0. Equality fires.
- Handshake:
  - spike_valid stays high until a cycle with spike_valid & spike_ready; it drops the following cycle.
  - spike_ready while spike_valid is low is ignored.
- Overrun: a new FIRE while spike_valid is still high and not accepted that cycle:
  - sets overrun, which is sticky until rst;
  - spike_valid stays high, so only one token is delivered;
  - spike_count still increments.
- FIRE coincident with acceptance of the old token: spike_valid stays high (new token), no overrun.
- thr_load: thr updates at the next edge. A compare in the same cycle as thr_load uses the old thr.
- en low:
  - no state transitions, no v_valid sampling, no counting;
  - the handshake still completes (spike_valid can drop);
  - if en falls during FIRE, the FIRE pulse still completes.

Optional Feature:
- Macro: SPIKE_GEN_ADAPTIVE_THRESH_EN.
- With the macro:
  - the effective threshold is thr + adapt, where adapt is an unsigned DATA_W register;
  - on each FIRE, adapt += ADAPT_STEP, saturating so that thr+adapt <= max positive;
  - on each en & v_valid in INTEG with no fire, adapt decrements by 1 toward 0;
  - rst clears adapt.
- Without the macro: adapt is absent and the effective threshold is thr.

Decomposition:
- Package snn_pkg holds:
  - DATA_W default;
  - state enum (INTEG, FIRE, REFRAC);
  - a saturating-increment function shared with spike_count and adapt.
- One natural sub-module: refrac_counter. It counts strobes up to REFRAC_STEPS and raises a done flag, with synchronous clear.

Test Plan:
- Reset, then v_mem=63 with v_valid, thr=64 -> no spk; v_mem=64 -> spk and acc_clear high exactly 1 cycle later, spike_count=1.
- Fire, then 3 v_valid strobes with v_mem=100 -> no spk during REFRAC (busy_refrac=1); 4th strobe -> fires again, spike_count=2.
- spike_ready held low, two fires separated by refractory -> overrun=1, spike_valid stays 1, count=2; then spike_ready=1 -> spike_valid drops next cycle.
- thr_load=1 with thr_in=-10 in the same cycle as v_valid with v_mem=-5 -> no fire (old thr=64); next strobe v_mem=-5 -> fires.
- rst asserted in the cycle after a fire while in REFRAC -> all outputs 0 next cycle and thr=64; a v_mem=64 strobe right after -> fires with no refractory wait.
- With SPIKE_GEN_ADAPTIVE_THRESH_EN: after a fire, v_mem=64 (past refractory) -> no fire because effective thr is 72; v_mem=72 -> fires.
